// File: rtl/uart_hamming_tx_pkg.sv
// Shared definitions for the UART Hamming(7,4) transmit path: FSM encoding,
// frame shape and the codeword bit-position map used by encoder and decoder.
package uart_hamming_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DATA_BITS = 7;
  localparam int unsigned STOP_BITS = 1;

  // Codeword layout {d3,d2,d1,p3,d0,p2,p1}; the decoder indexes the same map.
  localparam int unsigned POS_P1 = 0;
  localparam int unsigned POS_P2 = 1;
  localparam int unsigned POS_D0 = 2;
  localparam int unsigned POS_P3 = 3;
  localparam int unsigned POS_D1 = 4;
  localparam int unsigned POS_D2 = 5;
  localparam int unsigned POS_D3 = 6;

endpackage

// File: rtl/uart_hamming_tx_encoder.sv
// Pure combinational Hamming(7,4) encoder; mirror image of the receive-side
// decoder and usable directly as a reference model.
module hamming_encoder_74
  import uart_hamming_tx_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [6:0] code_o
);

  // Place data bits and even-parity bits into their codeword positions
  always_comb begin
    code_o         = 7'd0;
    code_o[POS_P1] = d_i[0] ^ d_i[1] ^ d_i[3];
    code_o[POS_P2] = d_i[0] ^ d_i[2] ^ d_i[3];
    code_o[POS_D0] = d_i[0];
    code_o[POS_P3] = d_i[1] ^ d_i[2] ^ d_i[3];
    code_o[POS_D1] = d_i[1];
    code_o[POS_D2] = d_i[2];
    code_o[POS_D3] = d_i[3];
  end

endmodule

// File: rtl/uart_hamming_tx.sv
// UART transmitter that Hamming(7,4)-encodes an accepted nibble and sends the
// codeword as start + 7 data bits (LSB first) + stop on a registered tx line.
module uart_hamming_tx
  import uart_hamming_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic [1:0] state_out,
  output logic [6:0] code_out
);

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_e  state_q, state_d;
  logic [7:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic       tx_q, tx_d;
  logic [6:0] code_q, code_d;
  logic [6:0] enc_code_s;
  logic       bit_end_s;
  logic [2:0] bit_nxt_s;

  hamming_encoder_74 u_enc (
    .d_i    (data_in),
    .code_o (enc_code_s)
  );

  assign bit_end_s = (baud_q == BAUD_LAST);
  assign bit_nxt_s = bit_q + 3'd1;

  // Next-state logic; a disabled cycle leaves every register unchanged
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    code_d  = code_q;
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          baud_d = 8'd0;
          bit_d  = 3'd0;
          tx_d   = 1'b1;
          if (data_valid) begin
            state_d = ST_START;
            code_d  = enc_code_s;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            baud_d  = 8'd0;
            bit_d   = 3'd0;
            state_d = ST_DATA;
            tx_d    = code_q[0];
          end else begin
            baud_d = baud_q + 8'd1;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            baud_d = 8'd0;
            if (bit_q == BIT_LAST) begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end else begin
              bit_d = bit_nxt_s;
              tx_d  = code_q[bit_nxt_s];
            end
          end else begin
            baud_d = baud_q + 8'd1;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            baud_d  = 8'd0;
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end else begin
            baud_d = baud_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          baud_d  = 8'd0;
          bit_d   = 3'd0;
          tx_d    = 1'b1;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers; reset drives the line idle-high immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= 8'd0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
      code_q  <= 7'd0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      code_q  <= code_d;
    end
  end

  assign data_ready = (state_q == ST_IDLE) && ena;
  assign busy       = (state_q != ST_IDLE);
  assign tx         = tx_q;
  assign state_out  = state_q;
  assign code_out   = code_q;

endmodule
